// File: rtl/line_capture_pkg.sv
// Shared types and helpers for the DPI line capture buffer.
package line_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_DEN,
        CAPTURE,
        SWAP
    } cap_state_e;

    // Address/counter width for n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_capture_buffer_if.sv
// Capture-side strobes and VGA-side read port of the line capture buffer.
interface line_capture_buffer_if
    import line_capture_pkg::*;
#(
    parameter int PIX_W = 3,
    parameter int X_W   = 11,
    parameter int DEPTH = 128
);
    localparam int AW = addr_w(DEPTH);

    logic             cap_pix_en;
    logic             cap_den;
    logic [PIX_W-1:0] cap_data;
    logic             cap_arm;
    logic [X_W-1:0]   rd_x;
    logic             rd_en;
    logic [PIX_W-1:0] rd_data;
    logic             line_ready;
    logic             overflow;
    logic [AW:0]      rd_len;

    modport master (
        output cap_pix_en, cap_den, cap_data, cap_arm, rd_x, rd_en,
        input  rd_data, line_ready, overflow, rd_len
    );

    modport slave (
        input  cap_pix_en, cap_den, cap_data, cap_arm, rd_x, rd_en,
        output rd_data, line_ready, overflow, rd_len
    );

endinterface

// File: rtl/line_bank_ram.sv
// One line bank: single write port, registered read port, BRAM-inferable.
module line_bank_ram #(
    parameter int PIX_W = 3,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic             clk_in,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a reset term would stop block-RAM inference,
    // and stale contents are never visible because reads are gated by the bank length.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_capture_buffer.sv
// Captures one decimated DPI line into a ping-pong bank pair and serves the
// last completed line to the display side with one cycle of read latency.
module line_capture_buffer
    import line_capture_pkg::*;
#(
    parameter int               PIX_W    = 3,
    parameter int               DEPTH    = 128,
    parameter int               DECIM    = 4,
    parameter int               RD_SHIFT = 2,
    parameter int               X_W      = 11,
    parameter logic [PIX_W-1:0] FILL     = '0
) (
    input  logic                 clk_in,
    input  logic                 reset,
    line_capture_buffer_if.slave bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = addr_w(DECIM);
    localparam int CW = (X_W > AW + 1) ? X_W : AW + 1;

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

    cap_state_e state_q, state_d;

    logic [AW:0]      waddr_q;
    logic [PW-1:0]    phase_q;
    logic             wbank_q;
    logic [AW:0]      len_q [2];
    logic             overflow_q;
    logic [AW:0]      rd_len;

    logic             strobe_den, strobe_gap;
    logic             take, empty_end, swap_en;
    logic             store, drop;
    logic [1:0]       bank_we;
    logic [PIX_W-1:0] bank_rdata [2];

    logic [CW-1:0]    idx;
    logic             hit_d, hit_q, rsel_q;

    assign strobe_den = bus.cap_pix_en & bus.cap_den;
    assign strobe_gap = bus.cap_pix_en & ~bus.cap_den;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: defaulting every comb output first keeps these blocks latch-free.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (bus.cap_arm) state_d = ARMED;
            ARMED:    if (strobe_gap)  state_d = WAIT_DEN;
            WAIT_DEN: if (strobe_den)  state_d = CAPTURE;
            CAPTURE:  if (strobe_gap)  state_d = (waddr_q != '0) ? SWAP : IDLE;
            SWAP:                      state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // The DEN-rising strobe seen in WAIT_DEN is already sample 0 of the line.
    always_comb begin
        take      = 1'b0;
        empty_end = 1'b0;
        swap_en   = 1'b0;
        unique case (state_q)
            WAIT_DEN: take = strobe_den;
            CAPTURE: begin
                take      = strobe_den;
                empty_end = strobe_gap && (waddr_q == '0);
            end
            SWAP:     swap_en = 1'b1;
            default: ;
        endcase
    end

    assign store   = take && (phase_q == '0) && (waddr_q < DEPTH_L);
    assign drop    = take && (phase_q == '0) && (waddr_q == DEPTH_L);
    assign bank_we = {store & wbank_q, store & ~wbank_q};

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            waddr_q    <= '0;
            phase_q    <= '0;
            wbank_q    <= 1'b0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (swap_en) begin
                len_q[wbank_q] <= waddr_q;
                wbank_q        <= ~wbank_q;
            end
            if (swap_en || empty_end) begin
                waddr_q <= '0;
                phase_q <= '0;
            end else if (take) begin
                if (store) begin
                    waddr_q <= waddr_q + (AW + 1)'(1);
                end
                phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Compare at full width so large x never aliases into a valid index.
    assign rd_len = len_q[~wbank_q];
    assign idx    = CW'(bus.rd_x) >> RD_SHIFT;
    assign hit_d  = bus.rd_en && (idx < CW'(rd_len));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank_ram #(
            .PIX_W (PIX_W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk_in (clk_in),
            .we     (bank_we[b]),
            .waddr  (waddr_q[AW-1:0]),
            .wdata  (bus.cap_data),
            .raddr  (idx[AW-1:0]),
            .rdata  (bank_rdata[b])
        );
    end

    // Bank select is captured with the read, so a read in the SWAP cycle
    // still resolves against the pre-swap bank.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            hit_q  <= 1'b0;
            rsel_q <= 1'b1;
        end else begin
            hit_q  <= hit_d;
            rsel_q <= ~wbank_q;
        end
    end

    assign bus.rd_data    = hit_q ? bank_rdata[rsel_q] : FILL;
    assign bus.rd_len     = rd_len;
    assign bus.line_ready = swap_en;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_line_capture_buffer.sv
// Randomised bench for line_capture_buffer against a line-level reference model.
module tb_line_capture_buffer;

    localparam int               PIX_W    = 3;
    localparam int               DEPTH    = 128;
    localparam int               DECIM    = 4;
    localparam int               RD_SHIFT = 2;
    localparam int               X_W      = 11;
    // Non-zero fill makes FILL distinguishable from an all-zero read.
    localparam logic [PIX_W-1:0] FILL     = 3'd5;

    logic clk_in = 1'b0;
    logic reset;

    always #5 clk_in = ~clk_in;

    line_capture_buffer_if #(.PIX_W(PIX_W), .X_W(X_W), .DEPTH(DEPTH)) bus ();

    line_capture_buffer #(
        .PIX_W    (PIX_W),
        .DEPTH    (DEPTH),
        .DECIM    (DECIM),
        .RD_SHIFT (RD_SHIFT),
        .X_W      (X_W),
        .FILL     (FILL)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lr_cnt   = 0;

    logic [PIX_W-1:0] m_line [DEPTH];
    int               m_len;
    bit               m_ovf;
    logic [PIX_W-1:0] sw_rd0, sw_rd1;

    always @(negedge clk_in) begin
        if (bus.line_ready === 1'b1) lr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [PIX_W-1:0] model_read(input int x, input bit en);
        int idx = x >> RD_SHIFT;
        return (en && idx < m_len) ? m_line[idx] : FILL;
    endfunction

    task automatic strobe(input bit den, input logic [PIX_W-1:0] d);
        bus.cap_pix_en = 1'b1;
        bus.cap_den    = den;
        bus.cap_data   = d;
        tick();
        bus.cap_pix_en = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic arm_pulse();
        bus.cap_arm = 1'b1;
        tick();
        bus.cap_arm = 1'b0;
    endtask

    task automatic read_check(input string tag, input int x, input bit en);
        bus.rd_x  = X_W'(x);
        bus.rd_en = en;
        tick();
        check(tag, 32'(bus.rd_data), 32'(model_read(x, en)));
    endtask

    task automatic read_sweep(input string tag, input int n_rand);
        for (int i = 0; i <= DEPTH + 1; i++)
            read_check(tag, (i << RD_SHIFT) + int'($urandom_range(0, (1 << RD_SHIFT) - 1)), 1'b1);
        for (int i = 0; i < n_rand; i++)
            read_check(tag, int'($urandom_range(0, (1 << X_W) - 1)), 1'($urandom_range(0, 1)));
        bus.rd_en = 1'b0;
    endtask

    // Arm, optional DEN-high prefix, DEN-low lead-in, line body, terminating gap strobe.
    task automatic send_line(input int pre_high, input int n_low, input int n_high, input bit ramp);
        logic [PIX_W-1:0] q[$];
        logic [PIX_W-1:0] d;
        int lr0 = lr_cnt;
        int cnt = 0;
        arm_pulse();
        repeat (pre_high) strobe(1'b1, PIX_W'($urandom));
        repeat (n_low) strobe(1'b0, PIX_W'($urandom));
        for (int i = 0; i < n_high; i++) begin
            d = ramp ? PIX_W'(i % 8) : PIX_W'($urandom);
            q.push_back(d);
            strobe(1'b1, d);
        end
        bus.cap_pix_en = 1'b1;
        bus.cap_den    = 1'b0;
        tick();
        bus.cap_pix_en = 1'b0;
        check("line_ready_on_swap", 32'(bus.line_ready), 32'(n_high > 0));
        tick();
        sw_rd0 = bus.rd_data;
        tick();
        sw_rd1 = bus.rd_data;
        repeat (2) tick();
        for (int i = 0; i < q.size(); i++) begin
            if (i % DECIM == 0) begin
                if (cnt < DEPTH) begin
                    m_line[cnt] = q[i];
                    cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (cnt > 0) m_len = cnt;
        check("line_ready_count", 32'(lr_cnt - lr0), 32'((n_high > 0) ? 1 : 0));
        check("rd_len", 32'(bus.rd_len), 32'(m_len));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    initial begin
        int lr0;
        int len0;
        logic [PIX_W-1:0] old_exp;

        reset          = 1'b0;
        bus.cap_pix_en = 1'b0;
        bus.cap_den    = 1'b0;
        bus.cap_data   = '0;
        bus.cap_arm    = 1'b0;
        bus.rd_x       = '0;
        bus.rd_en      = 1'b1;
        m_len          = 0;
        m_ovf          = 1'b0;

        repeat (3) tick();
        check("reset_rd_data", 32'(bus.rd_data), 32'(FILL));
        check("reset_rd_len", 32'(bus.rd_len), 32'd0);
        check("reset_line_ready", 32'(bus.line_ready), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        repeat (2) tick();
        read_check("post_reset_read", 0, 1'b1);

        // Ramp line: 40 strobes at DECIM=4 keep samples 0,4,...,36.
        send_line(0, 3, 40, 1'b1);
        check("dir_rd_len", 32'(bus.rd_len), 32'd10);
        bus.rd_en = 1'b1;
        bus.rd_x = 11'd0;  tick(); check("dir_x0", 32'(bus.rd_data), 32'd0);
        bus.rd_x = 11'd4;  tick(); check("dir_x4", 32'(bus.rd_data), 32'd4);
        bus.rd_x = 11'd8;  tick(); check("dir_x8", 32'(bus.rd_data), 32'd0);
        bus.rd_x = 11'd40; tick(); check("dir_x40", 32'(bus.rd_data), 32'(FILL));
        read_sweep("dir_sweep", 8);

        for (int l = 0; l < 4; l++) begin
            send_line(0, int'($urandom_range(1, 4)), int'($urandom_range(1, 250)), 1'b0);
            read_sweep("rand_sweep", 16);
        end

        // Constant read across the swap: old bank in the SWAP cycle, new one after.
        for (int k = 0; k < 2; k++) begin
            bus.rd_x  = X_W'((k == 0) ? 4 : 20);
            bus.rd_en = 1'b1;
            old_exp   = model_read(int'(bus.rd_x), 1'b1);
            send_line(0, 2, 60, 1'b0);
            check("swap_old_bank", 32'(sw_rd0), 32'(old_exp));
            check("swap_new_bank", 32'(sw_rd1), 32'(model_read(int'(bus.rd_x), 1'b1)));
            bus.rd_en = 1'b0;
        end

        send_line(0, 2, 600, 1'b0);
        check("ovf_rd_len", 32'(bus.rd_len), 32'(DEPTH));
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        read_sweep("ovf_sweep", 24);
        send_line(0, 2, 30, 1'b0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        read_sweep("ovf_next_sweep", 8);

        // Arm while DEN is already high: the partial line must be skipped.
        bus.cap_den = 1'b1;
        repeat (3) tick();
        send_line(6, 2, 24, 1'b0);
        read_sweep("midline_sweep", 8);

        // Abort after 20 stored samples.
        arm_pulse();
        repeat (2) strobe(1'b0, PIX_W'($urandom));
        repeat (20 * DECIM) strobe(1'b1, PIX_W'($urandom));
        bus.rd_x  = '0;
        bus.rd_en = 1'b1;
        reset     = 1'b0;
        tick();
        m_len = 0;
        m_ovf = 1'b0;
        check("abort_rd_data", 32'(bus.rd_data), 32'(FILL));
        check("abort_rd_len", 32'(bus.rd_len), 32'd0);
        check("abort_line_ready", 32'(bus.line_ready), 32'd0);
        check("abort_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        tick();
        read_check("abort_read0", 0, 1'b1);
        read_check("abort_read1", 8, 1'b1);
        send_line(0, 2, 50, 1'b0);
        read_sweep("after_abort_sweep", 8);

        // DEN pulse that no strobe samples: capture must not start or swap.
        lr0  = lr_cnt;
        len0 = m_len;
        arm_pulse();
        strobe(1'b0, PIX_W'($urandom));
        bus.cap_den = 1'b1;
        tick();
        bus.cap_den = 1'b0;
        tick();
        repeat (2) strobe(1'b0, PIX_W'($urandom));
        repeat (4) tick();
        check("zero_len_line_ready", 32'(lr_cnt - lr0), 32'd0);
        check("zero_len_rd_len", 32'(bus.rd_len), 32'(len0));
        read_sweep("zero_len_sweep", 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_capture_buffer.md
Name: line_capture_buffer

Overview:
- Captures one horizontal line of multi-bit pixel data from the Raspberry Pi DPI input while DEN is high, decimating it by a programmable factor.
- Stores the line in a ping-pong pair of line banks.
- Lets the VGA side read the last completed line at a scaled x position with a fixed 1-cycle latency.
- Generalises the current single-bit, fixed 90-entry heart register:
  - parametrised pixel width, depth, decimation and read scaling;
  - explicit arm/capture FSM;
  - bank swapping that removes read/write tearing;
  - a fill colour returned beyond the captured length.

Parameters:
- PIX_W, 3, bits per captured pixel (maps to one colour channel).
- DEPTH, 128, samples stored per line; AW = $clog2(DEPTH).
- DECIM, 4, one sample is stored per DECIM qualified pixel strobes; must be at least 1.
- RD_SHIFT, 2, read index = rd_x >> RD_SHIFT.
- X_W, 11, width of rd_x (matches h_count).
- FILL, 0, value returned for indices at or beyond the valid length of the read bank.

Ports:
- clk_in  in  1  system clock; all logic is in this domain.
- reset  in  1  asynchronous, active-low reset.
- cap_pix_en  in  1  pixel strobe, already synchronised into clk_in; one pulse per DPI pixel.
- cap_den  in  1  DPI data enable, synchronised; sampled only on cap_pix_en cycles.
- cap_data  in  PIX_W  pixel value; valid when cap_pix_en=1.
- cap_arm  in  1  request to capture the next DEN line (driven by the v_count-based trigger).
- rd_x  in  X_W  display x coordinate.
- rd_en  in  1  display active region.
- rd_data  out  PIX_W  registered pixel output.
- line_ready  out  1  one-cycle pulse on bank swap.
- overflow  out  1  sticky flag: a line exceeded DEPTH samples; cleared by reset only.
- rd_len  out  AW+1  valid sample count of the current read bank.

Behaviour:
- Reset values while reset=0:
  - state=IDLE, write bank=0, read bank=1;
  - rd_len=0, both bank lengths=0, rd_data=FILL;
  - line_ready=0, overflow=0, phase counter=0, write address=0.
  - Bank RAM contents are not reset.
- FSM is evaluated every clk_in; DEN edges are detected only on cap_pix_en cycles.
  - IDLE: cap_arm=1 -> ARMED.
  - ARMED: on a cap_pix_en cycle with cap_den=0 -> WAIT_DEN. This guarantees capture starts at a line start, never mid-line.
  - WAIT_DEN: on a cap_pix_en cycle with cap_den=1 -> CAPTURE.
    - This same strobe is sample 0: phase=0, so it is written at address 0.
  - CAPTURE: on each cap_pix_en with cap_den=1:
    - if phase==0 and waddr<DEPTH: write cap_data to wbank[waddr], then waddr++;
    - if phase==0 and waddr==DEPTH: set overflow and drop the sample;
    - phase = (phase==DECIM-1) ? 0 : phase+1.
  - CAPTURE, on a cap_pix_en with cap_den=0 (end of line):
    - if waddr>0: go to SWAP;
    - if waddr==0: go to IDLE with no swap.
  - SWAP (one cycle):
    - write bank and read bank exchange;
    - the new read bank's length = waddr;
    - line_ready=1 for this cycle;
    - waddr and phase cleared -> IDLE.
- cap_arm is ignored outside IDLE; no queuing.
- Read path:
  - idx = rd_x >> RD_SHIFT.
  - rd_data on the next clk_in edge:
    - = rbank[idx] if rd_en=1 and idx < rd_len;
    - else = FILL.
  - Latency is exactly 1 cycle.
- Simultaneous swap and read: a read issued in the SWAP cycle uses the pre-swap read bank. The new bank is visible from the following cycle.
- The write bank is never the read bank, so there is no read-during-write hazard.
- Reset asserted mid-capture aborts the capture immediately. After reset, reads return FILL until the first completed line.
- Arithmetic:
  - waddr and rd_len are AW+1 bits so that DEPTH itself is representable.
  - idx comparison is unsigned at full X_W width; no truncation before the compare.

Decomposition:
- Package line_capture_pkg: state enum (IDLE, ARMED, WAIT_DEN, CAPTURE, SWAP) and a clog2-derived width localparam helper.
- Sub-module line_bank_ram:
  - one write port and one registered read port;
  - PIX_W x DEPTH, no reset, inferable as BRAM;
  - instantiated twice, with bank select muxing in the parent.

Test Plan:
- DECIM=4, DEPTH=128:
  - Stimulus: arm, DEN low for 3 strobes, then DEN high for 40 strobes with cap_data=strobe index mod 8.
  - Required: line_ready pulses once; rd_len=10; rd_x=0,4,8 read 0,4,0; rd_x=40 reads FILL.
- Overflow:
  - Stimulus: DEN high for 600 strobes with DECIM=4.
  - Required: rd_len=128; overflow=1 and stays 1 through later normal lines.
- Mid-line arm:
  - Stimulus: arm asserted while DEN is already high.
  - Required: no samples are written until DEN goes low then high again; the first stored sample is that line's first pixel.
- Swap boundary:
  - Stimulus: hold rd_x constant across the SWAP cycle.
  - Required: rd_data shows the old bank value for the read issued in the SWAP cycle and the new bank value for the read issued one cycle later.
- Reset mid-capture:
  - Stimulus: assert reset after 20 samples.
  - Required: rd_data=FILL, rd_len=0, line_ready=0. The next full capture completes normally.
- Zero-length line:
  - Stimulus: arm, then a DEN pulse shorter than one strobe.
  - Required: no line_ready; rd_len is unchanged.
